// File: rtl/seg_scan_decoder.sv
// Readback decoder for a multiplexed active-low seven-segment bus: debounces each
// scan slot and recovers the hex code, error and decimal-point state per digit.
module seg_scan_decoder #(
  parameter int N_DIG      = 8,
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_DIG-1:0]                            an,
  input  logic [7:0]                                  patt,
  output logic [4*N_DIG-1:0]                          codes,
  output logic [N_DIG-1:0]                            valid,
  output logic [N_DIG-1:0]                            err,
  output logic [N_DIG-1:0]                            dp,
  output logic                                        upd,
  output logic [((N_DIG > 1) ? $clog2(N_DIG) : 1)-1:0] upd_idx,
  output logic                                        stale
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);

  logic [N_DIG-1:0] r_an, r_an_prev;
  logic [7:0]       r_patt, r_patt_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wdog;

  logic             w_same;
  logic [CNT_W-1:0] w_cnt_next;
  logic [N_DIG-1:0] w_sel;
  logic             w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_cap;
  logic             w_hit;
  logic [3:0]       w_code;
  logic             w_blank;

  // Inverse of the encoder table; only bits 6..0 take part in the match.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] res;
    res = 5'b0_0000;
    case (p)
      7'h40: res = 5'h10;
      7'h79: res = 5'h11;
      7'h24: res = 5'h12;
      7'h30: res = 5'h13;
      7'h19: res = 5'h14;
      7'h12: res = 5'h15;
      7'h02: res = 5'h16;
      7'h78: res = 5'h17;
      7'h00: res = 5'h18;
      7'h10: res = 5'h19;
      7'h08: res = 5'h1A;
      7'h03: res = 5'h1B;
      7'h46: res = 5'h1C;
      7'h21: res = 5'h1D;
      7'h06: res = 5'h1E;
      7'h0E: res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  assign w_same = (r_an == r_an_prev) && (r_patt == r_patt_prev);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_cnt_next = CNT_W'(1);
    if (w_same) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
    end
  end

  assign w_sel    = ~r_an;
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - N_DIG'(1))) == '0);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (w_sel[i]) w_idx = IDX_W'(i);
    end
  end

  // A change always restarts the count at 1, so reaching the limit from a change
  // is a fresh window; a saturated, unchanged count never recaptures.
  assign w_cap = (w_cnt_next == CNT_MAX) && (!w_same || (r_cnt != CNT_MAX)) && w_onehot;

  assign {w_hit, w_code} = seg_decode(r_patt[6:0]);
  assign w_blank         = (r_patt[6:0] == 7'h7F);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments and every register is cleared here.
      r_an        <= '0;
      r_an_prev   <= '0;
      r_patt      <= '0;
      r_patt_prev <= '0;
      r_cnt       <= '0;
      r_wdog      <= '0;
      codes       <= '0;
      valid       <= '0;
      err         <= '0;
      dp          <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      stale       <= 1'b0;
    end else begin
      r_an        <= an;
      r_patt      <= patt;
      r_an_prev   <= r_an;
      r_patt_prev <= r_patt;
      r_cnt       <= w_cnt_next;
      upd         <= w_cap;

      if (w_cap) begin
        upd_idx    <= w_idx;
        dp[w_idx]  <= ~r_patt[7];
        r_wdog     <= '0;
        stale      <= 1'b0;
        if (w_hit) begin
          codes[4*w_idx +: 4] <= w_code;
          valid[w_idx]        <= 1'b1;
          err[w_idx]          <= 1'b0;
        end else begin
          valid[w_idx] <= 1'b0;
          err[w_idx]   <= ~w_blank;
        end
      end else if (r_wdog >= WD_LAST) begin
        r_wdog <= WD_MAX;
        stale  <= 1'b1;
        valid  <= '0;
      end else begin
        r_wdog <= r_wdog + WD_W'(1);
      end
    end
  end

endmodule
